// File: rtl/hdp_reg_sequencer.sv
// Register-command sequencer in front of the HDP-1280-2 SPI master: queues host
// read/write commands, issues each as one 16-bit transfer and returns one response.
module hdp_reg_sequencer #(
  parameter int WORD_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int RX_SETTLE_CYCLES = 100,
  parameter int TIMEOUT_CYCLES   = 4095
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_rw,
  input  logic [6:0]            i_cmd_addr,
  input  logic [WORD_WIDTH-1:0] i_cmd_data,
  output logic                  o_rsp_valid,
  output logic                  o_rsp_rw,
  output logic [6:0]            o_rsp_addr,
  output logic [WORD_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_timeout,
  output logic                  o_spi_start,
  output logic [WORD_WIDTH-1:0] o_spi_upper,
  output logic [WORD_WIDTH-1:0] o_spi_lower,
  input  logic                  i_spi_busy,
  input  logic                  i_spi_complete,
  input  logic [WORD_WIDTH-1:0] i_spi_rx_lower,
  output logic                  o_idle
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 1 + 7 + WORD_WIDTH;
  // Timer reads k-1 in the k-th cycle after the start pulse, so the last
  // accepted completion lands exactly TIMEOUT_CYCLES cycles after start.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'((RX_SETTLE_CYCLES > 0) ? RX_SETTLE_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_DONE, S_SETTLE, S_RESPOND
  } state_t;

  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  ready_q;
  logic                  push, pop;
  logic [EW-1:0]         head;
  logic                  head_rw;
  logic [6:0]            head_addr;
  logic [WORD_WIDTH-1:0] head_data;

  state_t                state_q;
  logic [15:0]           timer_q, settle_q;
  logic                  cur_rw_q;
  logic [6:0]            cur_addr_q;
  logic                  spi_start_q;
  logic [WORD_WIDTH-1:0] spi_upper_q, spi_lower_q;
  logic                  rsp_valid_q, rsp_rw_q, rsp_timeout_q;
  logic [6:0]            rsp_addr_q;
  logic [WORD_WIDTH-1:0] rsp_data_q;

  assign push      = i_cmd_valid && ready_q;
  assign pop       = (state_q == S_IDLE) && (count_q != '0) && i_enable && !i_spi_busy;
  assign head      = mem_q[rd_ptr_q];
  assign head_rw   = head[EW-1];
  assign head_addr = head[WORD_WIDTH +: 7];
  assign head_data = head[WORD_WIDTH-1:0];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (push) mem_q[wr_ptr_q] <= {i_cmd_rw, i_cmd_addr, i_cmd_data};
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d != CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      settle_q      <= '0;
      cur_rw_q      <= 1'b0;
      cur_addr_q    <= '0;
      spi_start_q   <= 1'b0;
      spi_upper_q   <= '0;
      spi_lower_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rw_q      <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      spi_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            cur_rw_q    <= head_rw;
            cur_addr_q  <= head_addr;
            spi_upper_q <= WORD_WIDTH'({head_rw, head_addr});
            spi_lower_q <= head_rw ? '0 : head_data;
            spi_start_q <= 1'b1;
            state_q     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          timer_q <= '0;
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // Completion takes priority over a timeout in the same cycle.
          if (i_spi_complete) begin
            settle_q <= '0;
            state_q  <= S_SETTLE;
          end else if (timer_q == TIMEOUT_LAST) begin
            rsp_valid_q   <= 1'b1;
            rsp_rw_q      <= cur_rw_q;
            rsp_addr_q    <= cur_addr_q;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b1;
            state_q       <= S_RESPOND;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_SETTLE: begin
          if (settle_q >= SETTLE_LAST) begin
            rsp_valid_q   <= 1'b1;
            rsp_rw_q      <= cur_rw_q;
            rsp_addr_q    <= cur_addr_q;
            rsp_data_q    <= cur_rw_q ? i_spi_rx_lower : '0;
            rsp_timeout_q <= 1'b0;
            state_q       <= S_RESPOND;
          end else begin
            settle_q <= settle_q + 16'd1;
          end
        end
        S_RESPOND: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready   = ready_q;
  assign o_spi_start   = spi_start_q;
  assign o_spi_upper   = spi_upper_q;
  assign o_spi_lower   = spi_lower_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rw      = rsp_rw_q;
  assign o_rsp_addr    = rsp_addr_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_timeout = rsp_timeout_q;
  assign o_idle        = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_hdp_reg_sequencer.sv
// Bench for hdp_reg_sequencer: directed scenarios with randomized command
// contents, a behavioural SPI-master model and per-command expected responses.
`timescale 1ns/1ps
module tb_hdp_reg_sequencer;
  localparam int W      = 8;
  localparam int RX_DLY = 60;
  localparam int NMAX   = 32;

  logic         clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic         cv = 1'b0, crw = 1'b0;
  logic [6:0]   caddr = '0;
  logic [W-1:0] cdata = '0;
  logic         busy = 1'b0, cpl = 1'b0;
  logic [W-1:0] rx = '0;
  logic         o_cmd_ready, o_rsp_valid, o_rsp_rw, o_rsp_timeout, o_spi_start, o_idle;
  logic [6:0]   o_rsp_addr;
  logic [W-1:0] o_rsp_data, o_spi_upper, o_spi_lower;

  hdp_reg_sequencer dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en),
    .i_cmd_valid(cv), .o_cmd_ready(o_cmd_ready), .i_cmd_rw(crw),
    .i_cmd_addr(caddr), .i_cmd_data(cdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rw(o_rsp_rw), .o_rsp_addr(o_rsp_addr),
    .o_rsp_data(o_rsp_data), .o_rsp_timeout(o_rsp_timeout),
    .o_spi_start(o_spi_start), .o_spi_upper(o_spi_upper), .o_spi_lower(o_spi_lower),
    .i_spi_busy(busy), .i_spi_complete(cpl), .i_spi_rx_lower(rx),
    .o_idle(o_idle)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-command plan, filled at push time: SPI delay (0 = never completes), read value.
  int           beh_dly [NMAX];
  logic [W-1:0] beh_rx  [NMAX];
  logic         e_rw    [NMAX];
  logic [6:0]   e_addr  [NMAX];
  logic [W-1:0] e_data  [NMAX];
  int           push_cyc[NMAX];
  int           n_push = 0;

  // Observations recorded by the SPI model / monitor.
  int           n_start = 0, n_rsp = 0;
  int           st_cyc [NMAX];
  logic [W-1:0] st_up  [NMAX], st_lo[NMAX];
  logic         st_busy[NMAX];
  int           rs_cyc [NMAX];
  logic         rs_rw  [NMAX], rs_to[NMAX];
  logic [6:0]   rs_addr[NMAX];
  logic [W-1:0] rs_data[NMAX];
  logic         spur_req = 1'b0;

  initial begin
    int cpl_left, rx_left, busy_left, k;
    logic [W-1:0] rx_pend;
    cpl_left = 0; rx_left = 0; busy_left = 0; rx_pend = '0;
    forever begin
      @(negedge clk);
      cpl = 1'b0;
      if (o_rsp_valid === 1'b1 && n_rsp < NMAX) begin
        rs_cyc[n_rsp]  = cyc;           rs_rw[n_rsp]   = o_rsp_rw;
        rs_addr[n_rsp] = o_rsp_addr;    rs_data[n_rsp] = o_rsp_data;
        rs_to[n_rsp]   = o_rsp_timeout; n_rsp++;
      end
      if (o_spi_start === 1'b1 && n_start < NMAX) begin
        k = n_start;
        st_cyc[k] = cyc; st_up[k] = o_spi_upper; st_lo[k] = o_spi_lower; st_busy[k] = busy;
        rx = W'($urandom);
        rx_pend   = beh_rx[k];
        busy      = 1'b1;
        cpl_left  = beh_dly[k];
        busy_left = (beh_dly[k] > 0) ? beh_dly[k] + 3 : 20;
        rx_left   = 0;
        n_start++;
      end else begin
        if (rx_left > 0) begin rx_left--; if (rx_left == 0) rx = rx_pend; end
        if (cpl_left > 0) begin cpl_left--; if (cpl_left == 0) begin cpl = 1'b1; rx_left = RX_DLY; end end
        if (busy_left > 0) begin busy_left--; if (busy_left == 0) busy = 1'b0; end
        if (spur_req) cpl = 1'b1;
      end
    end
  end

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic rw, input logic [6:0] a, input logic [W-1:0] d,
                          input int dly, input logic [W-1:0] rxv);
    int guard;
    guard = 0;
    beh_dly[n_push] = dly; beh_rx[n_push] = rxv;
    e_rw[n_push] = rw; e_addr[n_push] = a; e_data[n_push] = d;
    @(negedge clk);
    while (o_cmd_ready !== 1'b1 && guard < 10000) begin @(negedge clk); guard++; end
    cv = 1'b1; crw = rw; caddr = a; cdata = d;
    push_cyc[n_push] = cyc;
    @(posedge clk); #1 cv = 1'b0;
    n_push++;
  endtask

  task automatic push_rand(input int dly);
    push_cmd(1'($urandom), 7'($urandom), W'($urandom), dly, W'($urandom));
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int t;
    t = 0;
    while (n_rsp < n && t < budget) begin @(negedge clk); t++; end
    chk($sformatf("rsp_count_%0d", n), 32'(n_rsp), 32'(n));
  endtask

  task automatic spur_pulse();
    spur_req = 1'b1;
    repeat (3) @(negedge clk);
    spur_req = 1'b0;
  endtask

  // Expected response follows directly from the command and how the SPI side behaved.
  task automatic check_cmd(input int k);
    logic [W-1:0] ed;
    int lat;
    ed  = (beh_dly[k] == 0) ? '0 : (e_rw[k] ? beh_rx[k] : '0);
    lat = (beh_dly[k] == 0) ? 4096 : beh_dly[k] + 1 + 100;
    chk($sformatf("c%0d_upper", k), 32'(st_up[k]), 32'({e_rw[k], e_addr[k]}));
    chk($sformatf("c%0d_lower", k), 32'(st_lo[k]), 32'(e_rw[k] ? '0 : e_data[k]));
    chk($sformatf("c%0d_busy_at_start", k), 32'(st_busy[k]), 32'(0));
    chk($sformatf("c%0d_rsp_rw", k), 32'(rs_rw[k]), 32'(e_rw[k]));
    chk($sformatf("c%0d_rsp_addr", k), 32'(rs_addr[k]), 32'(e_addr[k]));
    chk($sformatf("c%0d_rsp_data", k), 32'(rs_data[k]), 32'(ed));
    chk($sformatf("c%0d_rsp_timeout", k), 32'(rs_to[k]), 32'(beh_dly[k] == 0));
    chk($sformatf("c%0d_rsp_latency", k), 32'(rs_cyc[k] - st_cyc[k]), 32'(lat));
  endtask

  initial begin
    int first, guard;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(o_cmd_ready), 32'(1));
    chk("rst_idle", 32'(o_idle), 32'(1));
    chk("rst_start", 32'(o_spi_start), 32'(0));
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'(0));
    chk("rst_upper_lower", 32'({o_spi_upper, o_spi_lower}), 32'(0));
    chk("rst_rsp_fields", 32'({o_rsp_rw, o_rsp_addr, o_rsp_data, o_rsp_timeout}), 32'(0));
    rst = 1'b0;

    // Spurious completion in IDLE right after reset.
    spur_pulse();
    repeat (10) @(negedge clk);
    chk("spur_no_start", 32'(n_start), 32'(0));
    chk("spur_no_rsp", 32'(n_rsp), 32'(0));

    en = 1'b1;
    push_cmd(1'b0, 7'h12, 8'hA5, 900, 8'h77);
    wait_rsp(1, 2000);
    check_cmd(0);
    chk("c0_start_latency", 32'(st_cyc[0] - push_cyc[0]), 32'(2));
    chk("c0_one_start", 32'(n_start), 32'(1));

    push_cmd(1'b1, 7'h05, 8'hEE, $urandom_range(20, 300), 8'h3C);
    wait_rsp(2, 1000);
    check_cmd(1);
    chk("c1_start_latency", 32'(st_cyc[1] - push_cyc[1]), 32'(2));

    // Disabled: commands queue, nothing launches, stray completion ignored.
    en = 1'b0;
    push_rand($urandom_range(1, 80));
    push_rand($urandom_range(1, 80));
    spur_pulse();
    repeat (20) @(negedge clk);
    chk("dis_no_start", 32'(n_start), 32'(2));
    chk("dis_no_rsp", 32'(n_rsp), 32'(2));
    chk("dis_not_idle", 32'(o_idle), 32'(0));
    en = 1'b1;
    wait_rsp(4, 1000);
    check_cmd(2);
    check_cmd(3);

    // Fill the FIFO while disabled; the fifth push waits for the first pop.
    en = 1'b0;
    first = n_push;
    for (int i = 0; i < 4; i++) push_rand($urandom_range(1, 60));
    @(negedge clk);
    chk("full_ready_low", 32'(o_cmd_ready), 32'(0));
    en = 1'b1;
    push_rand($urandom_range(1, 60));
    chk("fifth_push_at_first_pop", 32'(push_cyc[first + 4]), 32'(st_cyc[first]));
    wait_rsp(9, 2000);
    for (int k = 4; k < 9; k++) check_cmd(k);

    // Never-completing transfer times out, then the queued one launches.
    push_cmd(1'b1, 7'($urandom), W'($urandom), 0, W'($urandom));
    push_rand($urandom_range(1, 200));
    wait_rsp(11, 6000);
    check_cmd(9);
    check_cmd(10);
    chk("after_timeout_launch", 32'(st_cyc[10] - rs_cyc[9]), 32'(2));
    @(negedge clk);
    chk("idle_after_drain", 32'(o_idle), 32'(1));

    // Reset in the middle of a long transfer with another command queued.
    push_rand(2000);
    push_rand(10);
    guard = 0;
    while (n_start < 12 && guard < 100) begin @(negedge clk); guard++; end
    chk("inflight_started", 32'(n_start), 32'(12));
    repeat (50) @(negedge clk);
    chk("rsp_fields_hold", 32'({o_rsp_rw, o_rsp_addr}), 32'({e_rw[10], e_addr[10]}));
    #3 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(o_cmd_ready), 32'(1));
    chk("arst_idle", 32'(o_idle), 32'(1));
    chk("arst_upper_lower", 32'({o_spi_upper, o_spi_lower}), 32'(0));
    chk("arst_rsp_fields", 32'({o_rsp_valid, o_rsp_rw, o_rsp_addr, o_rsp_data, o_rsp_timeout}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2200) @(negedge clk);
    chk("dropped_no_rsp", 32'(n_rsp), 32'(11));
    chk("dropped_no_start", 32'(n_start), 32'(12));
    chk("fifo_empty_after_rst", 32'(o_idle), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hdp_reg_sequencer.md
Name: hdp_reg_sequencer

Overview:
- Command sequencer directly upstream of the HDP-1280-2 SPI master.
- Accepts register read/write commands from the host/UART-FIFO side through a valid/ready interface and buffers them in a small FIFO.
- Issues each command as one 16-bit SPI transfer, waits for completion, and returns one response per command (read data or write ack) with a timeout flag.

Parameters:
- WORD_WIDTH, 8: SPI byte width.
- FIFO_DEPTH, 4: command FIFO entries; power of 2.
- RX_SETTLE_CYCLES, 100: i_clock cycles to wait after the completion pulse before sampling read data (2 SPI bit periods).
- TIMEOUT_CYCLES, 4095: i_clock cycles allowed from the start pulse to the completion pulse.

Ports:
- i_clock  in  1  system clock, 50 MHz.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  permits launching new transfers.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  FIFO not full.
- i_cmd_rw  in  1  1=read, 0=write.
- i_cmd_addr  in  7  register address.
- i_cmd_data  in  WORD_WIDTH  write data; ignored for reads.
- o_rsp_valid  out  1  one-cycle response strobe.
- o_rsp_rw  out  1  rw of the completed command.
- o_rsp_addr  out  7  address of the completed command.
- o_rsp_data  out  WORD_WIDTH  read data; 0 for writes or on timeout.
- o_rsp_timeout  out  1  transfer did not complete.
- o_spi_start  out  1  one-cycle start pulse to the SPI master.
- o_spi_upper  out  WORD_WIDTH  {rw, addr}.
- o_spi_lower  out  WORD_WIDTH  write data, or 0 for reads.
- i_spi_busy  in  1  SPI master not idle.
- i_spi_complete  in  1  one-cycle completion pulse from the SPI master.
- i_spi_rx_lower  in  WORD_WIDTH  SPI received lower byte.
- o_idle  out  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset (async, immediate): all outputs 0 except o_cmd_ready=1 and o_idle=1. FIFO emptied; FSM forced to IDLE; counters cleared. Reset mid-transfer drops the in-flight command with no response.
- FIFO:
  - Push on i_cmd_valid && o_cmd_ready, storing {rw, addr, data}.
  - o_cmd_ready = !full, registered so it reflects the count after this cycle.
  - Pop only on IDLE→LAUNCH. Simultaneous push and pop keeps the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH; the count is FIFO_DEPTH+1 states wide.
- FSM states: IDLE, LAUNCH, WAIT_DONE, SETTLE, RESPOND.
  - IDLE: go to LAUNCH when FIFO non-empty && i_enable && !i_spi_busy. Pop the head and register o_spi_upper={rw,addr} and o_spi_lower=(rw?0:data).
  - LAUNCH: o_spi_start=1 for exactly one cycle; clear the timer; go to WAIT_DONE. o_spi_upper and o_spi_lower stay stable from LAUNCH until leaving SETTLE.
  - WAIT_DONE: timer increments each cycle.
    - i_spi_complete → SETTLE, with the settle counter cleared.
    - Timer == TIMEOUT_CYCLES with no complete → RESPOND with timeout=1 and data=0.
    - If both occur in the same cycle, complete wins.
  - SETTLE: count RX_SETTLE_CYCLES, then capture i_spi_rx_lower into the response data (reads only) → RESPOND.
  - RESPOND: o_rsp_valid=1 for one cycle with rw/addr/data/timeout; return to IDLE. The response fields hold their values until the next RESPOND.
- i_spi_complete is ignored in every state except WAIT_DONE. This covers the spurious pulse from the SPI master after reset.
- i_enable low does not abort an in-flight command; it only blocks IDLE→LAUNCH. The FIFO keeps accepting commands while disabled.
- Minimum command-to-start latency from an empty FIFO: push at cycle N, o_spi_start at cycle N+2.
- Timer and settle counters are 16 bits; parameters must fit.
- o_idle = FIFO empty && state==IDLE.

Test Plan:
- Write 0x12←0xA5 with an SPI model asserting complete 900 cycles after start → upper=0x12, lower=0xA5, one start pulse; rsp_valid once with rw=0, addr=0x12, data=0x00, timeout=0.
- Read 0x05 with the model returning 0x3C, rx valid 60 cycles after complete → upper=0x85, lower=0x00; rsp data=0x3C sampled after 100 settle cycles.
- Push 5 back-to-back commands → ready falls after the 4th; the 5th is accepted after the first pop. Responses arrive in push order; start pulses only occur while busy=0.
- Model never completes → rsp at start+4096 cycles with timeout=1, data=0; the next queued command then launches.
- Complete pulse while IDLE after reset, and i_enable=0 with 2 queued commands → no response, no start; raising enable launches both in order.
- Assert reset during WAIT_DONE → outputs return to reset values immediately; no response for the dropped command; the FIFO is empty afterwards.
